net_tx_scheduler: RTL and testbench
===================================

# net_tx_scheduler

Packet-granular round-robin arbiter and token-bucket rate limiter sharing one 64-bit transmit flit stream among N requesters. It sits between the NIC send paths (or several NICs in a simulated switch port) and the simulated network endpoint's `net_out` stream. It consumes the endpoint's `rlimit_inc` / `rlimit_period` / `rlimit_size` configuration to pace egress bandwidth. A granted port owns the output until its `last` flit transfers, so packets are never interleaved.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters; 2..16.
- `DATA_W`, 64: flit data width; `keep` is `DATA_W/8`.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in N_PORTS: per-port flit valid.
- `in_ready` out N_PORTS: per-port flit accept.
- `in_data` in N_PORTS*DATA_W: flattened; port i at `[i*DATA_W +: DATA_W]`.
- `in_keep` in N_PORTS*DATA_W/8: flattened byte enables.
- `in_last` in N_PORTS: final flit of packet.
- `out_valid` out 1: flit to network.
- `out_ready` in 1: network accept.
- `out_data` out DATA_W; `out_keep` out DATA_W/8; `out_last` out 1: muxed flit.
- `rlimit_inc` in 8: tokens added per tick.
- `rlimit_period` in 8: tick every `rlimit_period+1` cycles.
- `rlimit_size` in 8: bucket capacity, in flits.
- `grant_idx` out clog2(N_PORTS): current owner, debug.
- `busy` out 1: packet in progress.

## Operation
- FSM states IDLE, BUSY.
- IDLE: when any `in_valid` is high, register grant = first requesting port searching from `rr_ptr+1` (mod N_PORTS) upward, then go to BUSY. No flit transfers in IDLE.
- BUSY: the grant is locked. The flit fires when `out_valid && out_ready`. On a fire with `in_last[grant]`: `rr_ptr <= grant`, return to IDLE.
- Token bucket, 9-bit internal arithmetic:
  - The period counter increments each cycle. A tick occurs when `cnt >= rlimit_period`, and the counter then clears to 0.
  - `tokens_next = min(tokens - fire + (tick ? rlimit_inc : 0), rlimit_size)`.
  - A token is consumed on every fired flit.
- Gating:
  - `out_valid = BUSY && in_valid[grant] && tokens != 0`.
  - `in_ready[grant] = BUSY && out_ready && tokens != 0`; all other `in_ready` are 0.
  - Data, keep and last are muxed combinationally from the granted port.

## Timing
- Reset values: state IDLE, `rr_ptr = N_PORTS-1` (so port 0 wins first), grant 0, tokens 0, cnt 0. All outputs 0 except the muxed data, which follows port 0.
- Arbitration latency is 1 cycle, from the first `in_valid` in IDLE to BUSY. Per-packet overhead is 1 idle cycle.
- Datapath: zero-latency combinational passthrough in BUSY. There is no buffering.
- Full rate: `rlimit_period=0`, `rlimit_inc>=1`. From reset, the first tick occurs in cycle 1; after that, tick and consume balance and throughput is 1 flit/cycle.
- Simultaneous tick and fire: both apply in the same cycle, then the result is clamped.
- Bucket full: a tick saturates at `rlimit_size`.
- `rlimit_size=0`: output permanently stalled, which is legal.
- Config change mid-run:
  - Lowering `rlimit_period` below `cnt` forces a tick next cycle.
  - Lowering `rlimit_size` clamps tokens on the next update.
- Tokens are 0 mid-packet: the grant is held, and `out_valid` drops until a refill.
- `in_valid[grant]` drops mid-packet: the grant is held and no other port may proceed.
- Reset mid-packet: the grant is abandoned immediately and the remainder of the packet is not recovered. Upstream must reset together with this block.

## Structure
- Package `net_sched_pkg`:
  - `sched_state_t` enum {IDLE, BUSY}.
  - `NET_DATA_W=64`, `NET_KEEP_W=8`, `RLIMIT_W=8`.
- Sub-module `net_token_bucket`: period counter, tokens, `tick`/`fire` in, `has_token` out. It is reusable for ingress pacing.
- The top level holds the FSM, the round-robin pointer and the mux.

## Test plan
- Single port, 3-flit packet, `period=0 inc=1 size=8`, `out_ready=1`:
  - Grant in cycle 1.
  - Flits out in cycles 2–4.
  - `out_last` in cycle 4; IDLE in cycle 5.
- Ports 0, 1, 3 each hold 2-flit packets continuously:
  - Grant order is 0,1,3,0,1,3.
  - There are no interleaved flits and no flit from port 2.
- Pacing, `inc=1 period=3 size=2`, 10-flit packet:
  - Sustained rate of 1 flit per 4 cycles.
  - After an idle gap of 20 cycles, a burst of exactly 2 back-to-back flits.
- Backpressure: hold `out_ready=0` for 5 cycles mid-packet.
  - The granted port's `in_ready` stays 0 and the flit stays stable on `out_data`.
  - Tokens are not consumed.
- Boundaries:
  - `size=0`: `out_valid` is never 1.
  - Raising `size` to 4 resumes transmission.
  - With tokens at 4, lowering `size` to 1 gives tokens 1 the next cycle.
- Reset asserted in flit 2 of 4:
  - The next cycle has `busy=0`, `out_valid=0`, tokens 0.
  - The next packet is granted to port 0.

Source files
------------

// File: rtl/net_sched_pkg.sv
// net_sched_pkg: shared FSM type and widths for the transmit scheduler
package net_sched_pkg;
  typedef enum logic {IDLE, BUSY} sched_state_t;
  localparam int NET_DATA_W = 64;
  localparam int NET_KEEP_W = 8;
  localparam int RLIMIT_W = 8;
endpackage

// File: rtl/net_tx_scheduler_if.sv
// net_tx_scheduler_if: per-port flit inputs and the muxed network flit stream
interface net_tx_scheduler_if import net_sched_pkg::*; #(
  parameter int N_PORTS = 4,
  parameter int DATA_W = NET_DATA_W
);
  logic [N_PORTS-1:0] in_valid;
  logic [N_PORTS-1:0] in_ready;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS*DATA_W/8-1:0] in_keep;
  logic [N_PORTS-1:0] in_last;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W/8-1:0] out_keep;
  logic out_last;
  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input in_ready, out_valid, out_data, out_keep, out_last
  );
  modport slave (
    input in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/net_token_bucket.sv
// net_token_bucket: periodic refill token bucket, one token per fired flit
module net_token_bucket import net_sched_pkg::*; (
  input logic clock,
  input logic reset,
  input logic [RLIMIT_W-1:0] rlimit_inc,
  input logic [RLIMIT_W-1:0] rlimit_period,
  input logic [RLIMIT_W-1:0] rlimit_size,
  input logic fire,
  output logic has_token
);
  logic [RLIMIT_W-1:0] cnt, tokens;
  logic [RLIMIT_W:0] sum;
  logic tick;
  // fire only happens with a token present, so the sum never underflows
  always_comb begin
    tick = cnt >= rlimit_period;
    sum = {1'b0, tokens} - {{RLIMIT_W{1'b0}}, fire} + (tick ? {1'b0, rlimit_inc} : '0);
  end
  assign has_token = tokens != '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      tokens <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      tokens <= (sum > {1'b0, rlimit_size}) ? rlimit_size : sum[RLIMIT_W-1:0];
    end
  end
endmodule

// File: rtl/net_tx_scheduler.sv
// net_tx_scheduler: packet-granular round-robin arbiter with token-bucket pacing
module net_tx_scheduler import net_sched_pkg::*; #(
  parameter int N_PORTS = 4,
  parameter int DATA_W = NET_DATA_W
) (
  input logic clock,
  input logic reset,
  net_tx_scheduler_if.slave bus,
  input logic [RLIMIT_W-1:0] rlimit_inc,
  input logic [RLIMIT_W-1:0] rlimit_period,
  input logic [RLIMIT_W-1:0] rlimit_size,
  output logic [$clog2(N_PORTS)-1:0] grant_idx,
  output logic busy
);
  localparam int GW = $clog2(N_PORTS);
  localparam int KW = DATA_W / 8;
  sched_state_t state, state_next;
  logic [GW-1:0] grant, grant_next, rr_ptr, rr_next, pick;
  logic [DATA_W-1:0] data_a [N_PORTS];
  logic [KW-1:0] keep_a [N_PORTS];
  logic has_token, fire;
  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v % N_PORTS);
  endfunction
  net_token_bucket u_bucket (
    .clock(clock),
    .reset(reset),
    .rlimit_inc(rlimit_inc),
    .rlimit_period(rlimit_period),
    .rlimit_size(rlimit_size),
    .fire(fire),
    .has_token(has_token)
  );
  // walk downward so the nearest requester after rr_ptr is the last one written
  always_comb begin
    pick = '0;
    for (int k = N_PORTS; k >= 1; k--)
      if (bus.in_valid[wrap(int'(rr_ptr) + k)]) pick = wrap(int'(rr_ptr) + k);
  end
  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next = rr_ptr;
    if (state == IDLE && |bus.in_valid) begin
      state_next = BUSY;
      grant_next = pick;
    end
    if (fire && bus.in_last[grant]) begin
      state_next = IDLE;
      rr_next = grant;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= GW'(N_PORTS - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      rr_ptr <= rr_next;
    end
  end
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      data_a[i] = bus.in_data[i*DATA_W +: DATA_W];
      keep_a[i] = bus.in_keep[i*KW +: KW];
    end
  end
  assign busy = state == BUSY;
  assign grant_idx = grant;
  assign bus.out_valid = busy && bus.in_valid[grant] && has_token;
  assign fire = bus.out_valid && bus.out_ready;
  assign bus.in_ready = (busy && bus.out_ready && has_token) ? {{(N_PORTS-1){1'b0}}, 1'b1} << grant : '0;
  assign bus.out_data = data_a[grant];
  assign bus.out_keep = keep_a[grant];
  assign bus.out_last = bus.in_last[grant];
endmodule

// File: tb/tb_net_tx_scheduler.sv
// tb_net_tx_scheduler: directed scenarios for arbitration, pacing, backpressure and reset
module tb_net_tx_scheduler;
  import net_sched_pkg::*;
  localparam int N = 4;
  localparam int W = NET_DATA_W;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [RLIMIT_W-1:0] rlimit_inc, rlimit_period, rlimit_size;
  logic [1:0] grant_idx;
  logic busy;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int pkts[N], plen[N], fidx[N], sent[N];
  logic [W-1:0] obs[$];
  int fire_cyc[$];

  net_tx_scheduler_if #(.N_PORTS(N), .DATA_W(W)) bus ();
  net_tx_scheduler #(.N_PORTS(N), .DATA_W(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .rlimit_inc(rlimit_inc),
    .rlimit_period(rlimit_period),
    .rlimit_size(rlimit_size),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] flit(input int i, input int p, input int f);
    return {8'(i), 40'h0, 8'(p), 8'(f)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i] = pkts[i] != 0;
      bus.in_last[i] = fidx[i] == plen[i] - 1;
      bus.in_data[i*W +: W] = flit(i, sent[i], fidx[i]);
      bus.in_keep[i*8 +: 8] = (fidx[i] == plen[i] - 1) ? 8'h0F : 8'hFF;
    end
  endtask

  // sample transfers at negedge, advance the sources just after the posedge
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clock);
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      obs.push_back(bus.out_data);
      fire_cyc.push_back(cyc);
    end
    @(posedge clock);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        if (fidx[i] == plen[i] - 1) begin
          fidx[i] = 0;
          sent[i]++;
          pkts[i]--;
        end else fidx[i]++;
      end
    drive();
    #1;
  endtask

  task automatic do_reset(input logic [7:0] inc, input logic [7:0] per, input logic [7:0] size);
    reset = 1'b1;
    rlimit_inc = inc;
    rlimit_period = per;
    rlimit_size = size;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pkts[i] = 0;
      plen[i] = 2;
      fidx[i] = 0;
      sent[i] = 0;
    end
    drive();
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    obs.delete();
    fire_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset(8'd1, 8'd0, 8'd8);
    n_cmp++; if ({busy, bus.out_valid, bus.in_ready, grant_idx} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000000", {busy, bus.out_valid, bus.in_ready, grant_idx}); end
    n_cmp++; if (dut.u_bucket.tokens !== 8'd0) begin n_fail++; $display("FAIL reset_tokens: got %0d want 0", dut.u_bucket.tokens); end
    n_cmp++; if (bus.out_data !== flit(0, 0, 0)) begin n_fail++; $display("FAIL reset_data: got %h want %h", bus.out_data, flit(0, 0, 0)); end
    step();
    n_cmp++; if ({busy, dut.u_bucket.tokens} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL first_tick: got busy %b tokens %0d want busy 0 tokens 1", busy, dut.u_bucket.tokens); end
  endtask

  task automatic test_single();
    do_reset(8'd1, 8'd0, 8'd8);
    plen[0] = 3;
    pkts[0] = 1;
    drive();
    #1;
    n_cmp++; if ({busy, bus.out_valid} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got busy/valid %b want 00", {busy, bus.out_valid}); end
    for (int f = 0; f < 3; f++) begin
      step();
      n_cmp++; if ({busy, grant_idx, bus.out_valid, bus.in_ready, bus.out_last, bus.out_data} !== {1'b1, 2'd0, 1'b1, 4'b0001, f == 2, flit(0, 0, f)}) begin
        n_fail++; $display("FAIL single_flit%0d: got busy %b grant %0d valid %b ready %b last %b data %h want 1 0 1 0001 %b %h", f, busy, grant_idx, bus.out_valid, bus.in_ready, bus.out_last, bus.out_data, f == 2, flit(0, 0, f));
      end
    end
    n_cmp++; if (bus.out_keep !== 8'h0F) begin n_fail++; $display("FAIL single_keep: got %h want 0f", bus.out_keep); end
    step();
    n_cmp++; if ({busy, bus.out_valid} !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy/valid %b want 00", {busy, bus.out_valid}); end
  endtask

  task automatic test_rr();
    int ep[6] = '{0, 1, 3, 0, 1, 3};
    do_reset(8'd1, 8'd0, 8'd8);
    pkts[0] = 2;
    pkts[1] = 2;
    pkts[3] = 2;
    drive();
    for (int t = 0; t < 60 && obs.size() < 12; t++) step();
    n_cmp++; if (obs.size() != 12) begin n_fail++; $display("FAIL rr_count: got %0d flits want 12", obs.size()); end
    for (int k = 0; k < 12 && k < obs.size(); k++) begin
      n_cmp++; if (obs[k] !== flit(ep[k/2], k/6, k%2)) begin n_fail++; $display("FAIL rr_flit%0d: got %h want %h", k, obs[k], flit(ep[k/2], k/6, k%2)); end
      n_cmp++; if (fire_cyc[k] != 3*(k/2) + 1 + k%2) begin n_fail++; $display("FAIL rr_cycle%0d: got %0d want %0d", k, fire_cyc[k], 3*(k/2) + 1 + k%2); end
    end
  endtask

  task automatic test_pacing();
    int v;
    int gap[4] = '{1, 2, 4, 8};
    do_reset(8'd1, 8'd3, 8'd2);
    plen[0] = 10;
    pkts[0] = 1;
    drive();
    for (int t = 0; t < 80 && fire_cyc.size() < 10; t++) step();
    n_cmp++; if (fire_cyc.size() != 10) begin n_fail++; $display("FAIL pace_count: got %0d flits want 10", fire_cyc.size()); end
    for (int k = 0; k < 10 && k < fire_cyc.size(); k++) begin
      n_cmp++; if (fire_cyc[k] != 4*(k+1)) begin n_fail++; $display("FAIL pace_fire%0d: got cycle %0d want %0d", k, fire_cyc[k], 4*(k+1)); end
    end
    repeat (20) step();
    while (cyc % 4 != 0) step();
    v = cyc;
    n_cmp++; if (dut.u_bucket.tokens !== 8'd2) begin n_fail++; $display("FAIL pace_full: got tokens %0d want 2", dut.u_bucket.tokens); end
    plen[0] = 4;
    pkts[0] = 1;
    drive();
    for (int t = 0; t < 30 && fire_cyc.size() < 14; t++) step();
    n_cmp++; if (fire_cyc.size() != 14) begin n_fail++; $display("FAIL burst_count: got %0d flits want 14", fire_cyc.size()); end
    for (int k = 0; k < 4 && 10 + k < fire_cyc.size(); k++) begin
      n_cmp++; if (fire_cyc[10+k] != v + gap[k]) begin n_fail++; $display("FAIL burst_fire%0d: got cycle %0d want %0d", k, fire_cyc[10+k], v + gap[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(8'd1, 8'd0, 8'd8);
    plen[0] = 4;
    pkts[0] = 1;
    drive();
    step();
    step();
    bus.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_cmp++; if ({bus.in_ready, bus.out_valid, bus.out_data} !== {4'b0000, 1'b1, flit(0, 0, 1)}) begin
        n_fail++; $display("FAIL stall%0d: got ready %b valid %b data %h want 0000 1 %h", j, bus.in_ready, bus.out_valid, bus.out_data, flit(0, 0, 1));
      end
      n_cmp++; if (dut.u_bucket.tokens !== 8'(1 + j)) begin n_fail++; $display("FAIL stall_tokens%0d: got %0d want %0d", j, dut.u_bucket.tokens, 1 + j); end
      step();
    end
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && obs.size() < 4; t++) step();
    n_cmp++; if (obs.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d flits want 4", obs.size()); end
    for (int k = 0; k < 4 && k < obs.size(); k++) begin
      n_cmp++; if (obs[k] !== flit(0, 0, k) || fire_cyc[k] != (k == 0 ? 1 : 6 + k)) begin
        n_fail++; $display("FAIL bp_flit%0d: got %h at %0d want %h at %0d", k, obs[k], fire_cyc[k], flit(0, 0, k), k == 0 ? 1 : 6 + k);
      end
    end
  endtask

  task automatic test_bounds();
    int s;
    logic seen;
    do_reset(8'd1, 8'd0, 8'd0);
    pkts[0] = 1;
    drive();
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      seen = seen | bus.out_valid;
    end
    n_cmp++; if ({seen, busy} !== 2'b01) begin n_fail++; $display("FAIL size0_stall: got seen/busy %b want 01", {seen, busy}); end
    rlimit_size = 8'd4;
    s = cyc;
    for (int t = 0; t < 10 && obs.size() < 2; t++) step();
    n_cmp++; if (obs.size() != 2 || fire_cyc[0] != s + 1) begin n_fail++; $display("FAIL size_resume: got %0d flits want 2 starting at %0d", obs.size(), s + 1); end
    repeat (6) step();
    n_cmp++; if (dut.u_bucket.tokens !== 8'd4) begin n_fail++; $display("FAIL size4_full: got %0d want 4", dut.u_bucket.tokens); end
    rlimit_size = 8'd1;
    step();
    n_cmp++; if (dut.u_bucket.tokens !== 8'd1) begin n_fail++; $display("FAIL size_clamp: got %0d want 1", dut.u_bucket.tokens); end
  endtask

  task automatic test_reset_mid();
    do_reset(8'd1, 8'd0, 8'd8);
    plen[2] = 4;
    pkts[1] = 1;
    pkts[2] = 1;
    drive();
    for (int t = 0; t < 30 && !(fidx[2] == 1 && busy); t++) step();
    n_cmp++; if ({busy, grant_idx} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL mid_grant: got busy %b grant %0d want 1 2", busy, grant_idx); end
    reset = 1'b1;
    step();
    n_cmp++; if ({busy, bus.out_valid, grant_idx, dut.u_bucket.tokens} !== {4'b0000, 8'd0}) begin
      n_fail++; $display("FAIL mid_reset: got busy %b valid %b grant %0d tokens %0d want 0 0 0 0", busy, bus.out_valid, grant_idx, dut.u_bucket.tokens);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pkts[i] = 1;
      plen[i] = 2;
      fidx[i] = 0;
      sent[i] = 0;
    end
    drive();
    step();
    n_cmp++; if ({busy, grant_idx} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL mid_regrant: got busy %b grant %0d want 1 0", busy, grant_idx); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_pacing();
    test_backpressure();
    test_bounds();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
